mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DFLT = 32;
  localparam int DATA_W_DFLT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and data access. Grants are registered, every access is followed by one IDLE
// cycle, and a fetch made stale by a branch flush completes silently.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's request
// FETCH | instruction read on the memory bus, waiting for mem_ready
// DATA  | load or store on the memory bus, waiting for mem_ready
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DFLT,
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  arb_state_e          state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                drop_q, drop_d;

  logic fetch_win;
  logic data_win;

  // Arbitration: data (older instruction) wins ties until fetch has waited MAX_STREAK grants.
  always_comb begin
    fetch_win = if_req && ((streak_q == STREAK_MAX) || !dm_req);
    data_win  = dm_req && !fetch_win;
  end

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    streak_d    = streak_q;
    drop_d      = drop_q;

    unique case (state_q)
      IDLE: begin
        // mem_ready is deliberately ignored here: no access is outstanding.
        if (fetch_win) begin
          state_d    = FETCH;
          mem_addr_d = if_addr;
          mem_we_d   = 1'b0;
          streak_d   = '0;
        end else if (data_win) begin
          state_d     = DATA;
          mem_addr_d  = dm_addr;
          mem_we_d    = dm_we;
          mem_wdata_d = dm_wdata;
          if (if_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
          end else begin
            streak_d = '0;
          end
        end
      end

      FETCH: begin
        if (flush) begin
          drop_d = 1'b1;
        end
        if (mem_ready) begin
          state_d    = IDLE;
          if_rdata_d = mem_rdata;
          // A flush on the completion cycle drops the word just like an earlier one.
          if_valid_d = !(drop_q || flush);
          drop_d     = 1'b0;
        end
      end

      DATA: begin
        if (mem_ready) begin
          state_d    = IDLE;
          dm_valid_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      streak_q    <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      streak_q    <= streak_d;
      drop_q      <= drop_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  // Stalls stay high through a dropped fetch because if_valid never pulses for it.
  assign if_stall  = if_req & ~if_valid_q;
  assign dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard of expected read words is
// filled by the stimulus and drained by a monitor on every valid pulse.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        flush = 1'b0;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    int          streak;
    int          cyc;
  } grant_t;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] if_exp[$];
  logic [31:0] dm_exp[$];
  grant_t      glog[$];
  logic [31:0] mem_model[logic [31:0]];
  int          mem_wait = 0;
  bit          tie_ready = 1'b0;
  int          if_vcyc;
  int          dm_vcyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: cycle budget expired, got timeout, expected completion", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ready after mem_wait extra cycles, or permanently when tied.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
    forever begin
      @(negedge clk);
      if (tie_ready) begin
        mem_ready = 1'b1;
        mem_rdata = mem_model[mem_addr];
      end else if (mem_req) begin
        if (wcnt >= mem_wait) begin
          mem_ready = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_model[mem_addr];
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Grant log: every rising mem_req is a new grant (an IDLE cycle always separates them).
  initial begin
    logic prev_req;
    grant_t g;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        g.we = mem_we;
        g.addr = mem_addr;
        g.streak = int'(dut.streak_q);
        g.cyc = cyc;
        glog.push_back(g);
      end
      prev_req = mem_req;
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (if_valid) begin
        if (if_exp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL if_unexpected: got if_valid with %h, expected no fetch response", if_rdata);
        end else begin
          check("if_rdata", if_rdata, if_exp.pop_front());
        end
      end
      if (dm_valid) begin
        if (dm_exp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dm_unexpected: got dm_valid with %h, expected no data response", dm_rdata);
        end else begin
          check("dm_rdata", dm_rdata, dm_exp.pop_front());
        end
      end
      if (if_valid || dm_valid) check("valid_exclusive", 32'(if_valid & dm_valid), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    glog.delete();
  endtask

  // Run cycles, dropping each requester when its valid arrives (data after dm_n pulses).
  task automatic serve(input string name, input int budget, input int dm_n, input bit chk_store);
    int dm_cnt;
    int k;
    dm_cnt = 0;
    k = 0;
    if_vcyc = -1;
    dm_vcyc = -1;
    while ((if_req || dm_req || mem_req) && k < budget) begin
      @(posedge clk); #1;
      k++;
      if (chk_store && mem_req) begin
        check("store_we", 32'(mem_we), 32'd1);
        check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("store_addr", mem_addr, 32'h200);
      end
      if (if_valid) begin
        if_req = 1'b0;
        if (if_vcyc < 0) if_vcyc = cyc;
      end
      if (dm_valid) begin
        dm_cnt++;
        if (dm_vcyc < 0) dm_vcyc = cyc;
        if (dm_cnt >= dm_n) dm_req = 1'b0;
      end
    end
    if (k >= budget) timeout(name);
  endtask

  initial begin
    mem_model[32'h0]   = 32'h0;
    mem_model[32'h40]  = 32'h8C01_0004;
    mem_model[32'h44]  = 32'h2442_0044;
    mem_model[32'h80]  = 32'h0000_1111;
    mem_model[32'h100] = 32'h1234_5678;
    mem_model[32'h200] = 32'h1111_1111;
    mem_model[32'h300] = 32'hA5A5_0300;

    // Reset state.
    do_reset();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_valids", 32'({if_valid, dm_valid}), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_streak", 32'(dut.streak_q), 32'd0);
    check("rst_drop", 32'(dut.drop_q), 32'd0);

    // Zero-wait fetch with mem_ready tied high (also exercises ready-in-IDLE).
    tie_ready = 1'b1;
    if_exp.push_back(32'h8C01_0004);
    if_req = 1'b1;
    if_addr = 32'h40;
    #1;
    check("t1_c0_stall", 32'(if_stall), 32'd1);
    check("t1_c0_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    check("t1_c1_mem_req", 32'(mem_req), 32'd1);
    check("t1_c1_addr", mem_addr, 32'h40);
    check("t1_c1_stall", 32'(if_stall), 32'd1);
    check("t1_c1_if_valid", 32'(if_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_c2_if_valid", 32'(if_valid), 32'd1);
    check("t1_c2_stall", 32'(if_stall), 32'd0);
    if_req = 1'b0;
    @(posedge clk); #1;
    tie_ready = 1'b0;
    check("t1_c3_mem_req", 32'(mem_req), 32'd0);

    // Contention: data wins, fetch follows in the next IDLE.
    mem_wait = 1;
    glog.delete();
    dm_exp.push_back(32'h1234_5678);
    if_exp.push_back(32'h8C01_0004);
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    serve("t2_serve", 40, 1, 1'b0);
    check("t2_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("t2_first_addr", glog[0].addr, 32'h100);
      check("t2_second_addr", glog[1].addr, 32'h40);
      check("t2_fetch_next_idle", 32'(glog[1].cyc), 32'(dm_vcyc + 1));
    end
    check("t2_dm_before_if", 32'(dm_vcyc < if_vcyc), 32'd1);

    // Starvation limit: four data grants, then fetch, then streak restarts.
    do_reset();
    mem_wait = 0;
    for (int i = 0; i < 5; i++) dm_exp.push_back(32'hA5A5_0300);
    if_exp.push_back(32'h2442_0044);
    if_req = 1'b1; if_addr = 32'h44;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    serve("t3_serve", 100, 5, 1'b0);
    check("t3_grants", 32'(glog.size()), 32'd6);
    if (glog.size() == 6) begin
      check("t3_g0_streak", 32'(glog[0].streak), 32'd1);
      check("t3_g3_addr", glog[3].addr, 32'h300);
      check("t3_g3_streak", 32'(glog[3].streak), 32'd4);
      check("t3_g4_addr", glog[4].addr, 32'h44);
      check("t3_g4_streak", 32'(glog[4].streak), 32'd0);
      check("t3_g5_addr", glog[5].addr, 32'h300);
      check("t3_g5_streak", 32'(glog[5].streak), 32'd0);
    end

    // Flush mid-fetch: stale 0x40 word dropped, new PC 0x80 fetched afterwards.
    do_reset();
    mem_wait = 3;
    if_exp.push_back(32'h0000_1111);
    if_req = 1'b1; if_addr = 32'h40;
    @(posedge clk); #1;
    check("t4_c1_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1; if_addr = 32'h80;
    @(posedge clk); #1;
    flush = 1'b0;
    check("t4_drop_set", 32'(dut.drop_q), 32'd1);
    check("t4_stall_held", 32'(if_stall), 32'd1);
    serve("t4_serve", 40, 1, 1'b0);
    check("t4_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("t4_first_addr", glog[0].addr, 32'h40);
      check("t4_second_addr", glog[1].addr, 32'h80);
    end

    // Store then load with two wait states; store leaves dm_rdata untouched.
    mem_wait = 2;
    dm_exp.push_back(32'hA5A5_0300);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    serve("t5_load0", 40, 1, 1'b0);
    dm_exp.push_back(32'hA5A5_0300);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    serve("t5_store", 40, 1, 1'b1);
    dm_exp.push_back(32'hDEAD_BEEF);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = 32'h0;
    serve("t5_load1", 40, 1, 1'b0);

    // Reset while a data access waits on the memory.
    mem_wait = 20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    @(posedge clk); #1;
    check("t6_mem_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    dm_req = 1'b0;
    @(posedge clk); #1;
    check("t6_mem_req", 32'(mem_req), 32'd0);
    check("t6_state", 32'(dut.state_q == IDLE), 32'd1);
    check("t6_mem_addr", mem_addr, 32'd0);
    check("t6_mem_we", 32'(mem_we), 32'd0);
    check("t6_if_rdata", if_rdata, 32'd0);
    check("t6_dm_rdata", dm_rdata, 32'd0);
    check("t6_valids", 32'({if_valid, dm_valid}), 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle_after", 32'(mem_req), 32'd0);

    check("if_queue_drained", 32'(if_exp.size()), 32'd0);
    check("dm_queue_drained", 32'(dm_exp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
